// File: rtl/toll_datapath_if.sv
// toll_datapath_if: lane-controller <-> toll datapath bundle.
//   master: drives the command strobes and E-pass card reads, observes results.
//   slave : the datapath; consumes commands and reports fee, balance,
//           occupancy and barrier status.
interface toll_datapath_if;
    logic        init, count, cal, up, down, en, dis;
    logic        epass_strobe;
    logic [11:0] epass_balance;
    logic        valid_Epass, enable, barrier_warn, txn_done;
    logic [1:0]  num_veh;
    logic [11:0] elapsed, fee_out, balance_out;
    modport master (
        output init, count, cal, up, down, en, dis, epass_strobe, epass_balance,
        input  valid_Epass, num_veh, enable, barrier_warn, elapsed, fee_out, balance_out, txn_done
    );
    modport slave (
        input  init, count, cal, up, down, en, dis, epass_strobe, epass_balance,
        output valid_Epass, num_veh, enable, barrier_warn, elapsed, fee_out, balance_out, txn_done
    );
endinterface

// File: rtl/toll_datapath.sv
// toll_datapath: transit timer, fee calculation, E-pass charging, zone occupancy and barrier control.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : toll_datapath_if.slave (commands and card reads in; fee, balance, occupancy, barrier out)
module toll_datapath #(
    parameter int TICK_DIV    = 4,
    parameter int FEE_BASE    = 10,
    parameter int FEE_RATE    = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int WARN_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    toll_datapath_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2((HOLD_CYCLES > WARN_CYCLES ? HOLD_CYCLES : WARN_CYCLES) + 1);

    typedef enum logic [1:0] {CLOSED, OPEN, CLOSING} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] pre;
    logic [11:0] elapsed, balance_q, fee_q, fee;
    logic [23:0] fee_w;
    logic [1:0]  nveh;
    logic        card_loaded, txn, valid;

    // Wide enough that FEE_BASE + FEE_RATE*4095 cannot overflow before saturation.
    assign fee_w = 24'(FEE_BASE) + 24'(FEE_RATE) * {12'd0, elapsed};
    assign fee   = fee_w > 24'd4095 ? 12'd4095 : fee_w[11:0];
    assign valid = card_loaded && balance_q >= fee;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre     <= '0;
            elapsed <= '0;
        end else if (bus.init) begin
            pre     <= '0;
            elapsed <= '0;
        end else if (bus.count) begin
            if (pre == PW'(TICK_DIV - 1)) begin
                pre <= '0;
                if (elapsed != 12'hfff) elapsed <= elapsed + 12'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    // A card read arriving while a charge is being evaluated is dropped so the
    // charged balance cannot be overwritten in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            balance_q   <= '0;
            fee_q       <= '0;
            card_loaded <= 1'b0;
            txn         <= 1'b0;
        end else begin
            txn <= bus.cal && valid;
            if (bus.cal && valid) begin
                balance_q   <= balance_q - fee;
                fee_q       <= fee;
                card_loaded <= 1'b0;
            end else if (bus.epass_strobe && !bus.cal) begin
                balance_q   <= bus.epass_balance;
                card_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) nveh <= '0;
        else if (bus.up && !bus.down && nveh != 2'd3) nveh <= nveh + 2'd1;
        else if (bus.down && !bus.up && nveh != 2'd0) nveh <= nveh - 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLOSED;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // One shared down-counter: holds the open time in OPEN, the warning time in CLOSING.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.dis) begin
            state_n = CLOSED;
        end else if (bus.en) begin
            state_n = OPEN;
            cnt_n   = CW'(HOLD_CYCLES - 1);
        end else if (state != CLOSED) begin
            cnt_n = cnt - CW'(1);
            if (cnt == '0) begin
                state_n = state == OPEN ? CLOSING : CLOSED;
                cnt_n   = CW'(WARN_CYCLES - 1);
            end
        end
    end

    assign bus.valid_Epass  = valid;
    assign bus.num_veh      = nveh;
    assign bus.enable       = state != CLOSED;
    assign bus.barrier_warn = state == CLOSING;
    assign bus.elapsed      = elapsed;
    assign bus.fee_out      = fee_q;
    assign bus.balance_out  = balance_q;
    assign bus.txn_done     = txn;
endmodule

// File: tb/tb_toll_datapath.sv
// tb_toll_datapath: directed scenarios plus random stimulus against a behavioural toll model.
module tb_toll_datapath;
    localparam int TICK_DIV = 4, FEE_BASE = 10, FEE_RATE = 2, HOLD = 8, WARN = 2;

    logic clk = 1'b0, reset = 1'b1;
    int checks = 0, errors = 0;

    toll_datapath_if bus();

    toll_datapath #(.TICK_DIV(TICK_DIV), .FEE_BASE(FEE_BASE), .FEE_RATE(FEE_RATE),
                    .HOLD_CYCLES(HOLD), .WARN_CYCLES(WARN))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: total counted cycles since init, remaining barrier-enabled cycles,
    // plain occupancy count and card wallet.
    int m_ticks, m_tl, m_n, m_bal, m_fee_out;
    bit m_loaded, m_txn;

    function automatic int m_elapsed();
        return (m_ticks / TICK_DIV) > 4095 ? 4095 : m_ticks / TICK_DIV;
    endfunction

    function automatic int m_fee();
        int f = FEE_BASE + FEE_RATE * m_elapsed();
        return f > 4095 ? 4095 : f;
    endfunction

    function automatic bit m_valid();
        return m_loaded && m_bal >= m_fee();
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ticks <= 0; m_tl <= 0; m_n <= 0; m_bal <= 0; m_fee_out <= 0;
            m_loaded <= 0; m_txn <= 0;
        end else begin
            m_txn <= bus.cal && m_valid();
            if (bus.cal && m_valid()) begin
                m_bal     <= m_bal - m_fee();
                m_fee_out <= m_fee();
                m_loaded  <= 0;
            end else if (bus.epass_strobe && !bus.cal) begin
                m_bal    <= int'(bus.epass_balance);
                m_loaded <= 1;
            end
            m_ticks <= bus.init ? 0 : bus.count ? m_ticks + 1 : m_ticks;
            m_n <= (bus.up && !bus.down) ? (m_n < 3 ? m_n + 1 : 3) :
                   (bus.down && !bus.up) ? (m_n > 0 ? m_n - 1 : 0) : m_n;
            m_tl <= bus.dis ? 0 : bus.en ? HOLD + WARN : (m_tl > 0 ? m_tl - 1 : 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("valid_Epass", int'(bus.valid_Epass), int'(m_valid()));
            chk("num_veh", int'(bus.num_veh), m_n);
            chk("enable", int'(bus.enable), int'(m_tl > 0));
            chk("barrier_warn", int'(bus.barrier_warn), int'(m_tl > 0 && m_tl <= WARN));
            chk("elapsed", int'(bus.elapsed), m_elapsed());
            chk("fee_out", int'(bus.fee_out), m_fee_out);
            chk("balance_out", int'(bus.balance_out), m_bal);
            chk("txn_done", int'(bus.txn_done), int'(m_txn));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        {bus.init, bus.count, bus.cal, bus.up, bus.down, bus.en, bus.dis, bus.epass_strobe} = '0;
        bus.epass_balance = '0;
    endtask

    task automatic load_card(input int b);
        bus.epass_strobe = 1; bus.epass_balance = 12'(b); step(); bus.epass_strobe = 0;
    endtask

    task automatic barrier_window();
        for (int i = 0; i < HOLD + WARN + 2; i++) begin
            probe();
            chk("lit_enable", int'(bus.enable), int'(i < HOLD + WARN));
            chk("lit_warn", int'(bus.barrier_warn), int'(i >= HOLD && i < HOLD + WARN));
        end
    endtask

    initial begin
        int exp_up[4] = '{1, 2, 3, 3};
        int exp_dn[4] = '{2, 1, 0, 0};
        clear_in();
        #12 reset = 0;
        probe();
        chk("rst_balance", int'(bus.balance_out), 0);
        chk("rst_valid", int'(bus.valid_Epass), 0);
        step();

        load_card(100);
        bus.init = 1; step(); bus.init = 0;
        bus.count = 1; step(40); bus.count = 0;
        probe();
        chk("lit_elapsed10", int'(bus.elapsed), 10);
        chk("lit_valid_before_cal", int'(bus.valid_Epass), 1);
        bus.cal = 1; step(); bus.cal = 0;
        probe();
        chk("lit_txn_high", int'(bus.txn_done), 1);
        chk("lit_balance70", int'(bus.balance_out), 70);
        chk("lit_fee30", int'(bus.fee_out), 30);
        chk("lit_valid_after_cal", int'(bus.valid_Epass), 0);
        step();
        probe();
        chk("lit_txn_low", int'(bus.txn_done), 0);

        load_card(20);
        bus.init = 1; step(); bus.init = 0;
        bus.count = 1; step(40); bus.count = 0;
        bus.cal = 1; step(); bus.cal = 0;
        probe();
        chk("lit_low_valid", int'(bus.valid_Epass), 0);
        chk("lit_low_balance", int'(bus.balance_out), 20);
        chk("lit_low_txn", int'(bus.txn_done), 0);
        chk("lit_low_fee_kept", int'(bus.fee_out), 30);

        for (int i = 0; i < 4; i++) begin
            bus.up = 1; step(); bus.up = 0; probe();
            chk("lit_up", int'(bus.num_veh), exp_up[i]);
        end
        bus.up = 1; bus.down = 1; step(); bus.up = 0; bus.down = 0; probe();
        chk("lit_updown", int'(bus.num_veh), 3);
        for (int i = 0; i < 4; i++) begin
            bus.down = 1; step(); bus.down = 0; probe();
            chk("lit_down", int'(bus.num_veh), exp_dn[i]);
        end

        bus.en = 1; step(); bus.en = 0;
        barrier_window();
        bus.en = 1; step(); bus.en = 0;
        step(4);
        bus.en = 1; step(); bus.en = 0;
        barrier_window();
        bus.en = 1; step(); bus.dis = 1; step(); bus.en = 0; bus.dis = 0;
        probe();
        chk("lit_en_dis", int'(bus.enable), 0);

        bus.init = 1; step(); bus.init = 0;
        bus.count = 1; step(20000); bus.count = 0;
        probe();
        chk("lit_elapsed_sat", int'(bus.elapsed), 4095);
        load_card(4095);
        bus.cal = 1; step(); bus.cal = 0;
        probe();
        chk("lit_fee_sat", int'(bus.fee_out), 4095);
        chk("lit_balance_zero", int'(bus.balance_out), 0);
        bus.init = 1; bus.count = 1; step(); bus.init = 0; bus.count = 0;
        probe();
        chk("lit_init_over_count", int'(bus.elapsed), 0);

        bus.up = 1; step(2); bus.up = 0;
        load_card(500);
        bus.count = 1; step(8); bus.count = 0;
        bus.en = 1; step(); bus.en = 0;
        step(2);
        @(negedge clk);
        #1 reset = 1;
        #1;
        chk("async_num_veh", int'(bus.num_veh), 0);
        chk("async_enable", int'(bus.enable), 0);
        chk("async_warn", int'(bus.barrier_warn), 0);
        chk("async_elapsed", int'(bus.elapsed), 0);
        chk("async_balance", int'(bus.balance_out), 0);
        chk("async_valid", int'(bus.valid_Epass), 0);
        chk("async_fee", int'(bus.fee_out), 0);
        chk("async_txn", int'(bus.txn_done), 0);
        @(posedge clk);
        #2 reset = 0;

        for (int i = 0; i < 3000; i++) begin
            bus.init          = ($urandom_range(31) == 0);
            bus.count         = ($urandom_range(1) == 0);
            bus.cal           = ($urandom_range(7) == 0);
            bus.up            = ($urandom_range(3) == 0);
            bus.down          = ($urandom_range(3) == 0);
            bus.en            = ($urandom_range(15) == 0);
            bus.dis           = ($urandom_range(31) == 0);
            bus.epass_strobe  = ($urandom_range(7) == 0);
            bus.epass_balance = $urandom_range(1) ? 12'($urandom_range(80)) : 12'($urandom);
            step();
        end
        clear_in();
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/toll_datapath.md
TOLL_DATAPATH -- requirements
Module: toll_datapath

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4: clock cycles per elapsed-time unit (>=1).
REQ-002 The block SHALL have parameter FEE_BASE, default 10: fixed fee component.
REQ-003 The block SHALL have parameter FEE_RATE, default 2: fee per elapsed-time unit.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 8: barrier open time in cycles.
REQ-005 The block SHALL have parameter WARN_CYCLES, default 2: barrier closing-warning time in cycles.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have ports init, count, cal, up, down, en and dis, each input, 1 bit: command strobes from the lane controller.
REQ-009 The block SHALL have port epass_strobe, input, 1 bit: one-cycle E-pass card read.
REQ-010 The block SHALL have port epass_balance, input, 12 bits: card balance, valid with epass_strobe.
REQ-011 The block SHALL have port valid_Epass, output, 1 bit: loaded card covers the current fee.
REQ-012 The block SHALL have port num_veh, output, 2 bits: vehicles in zone.
REQ-013 The block SHALL have port enable, output, 1 bit: barrier open.
REQ-014 The block SHALL have port barrier_warn, output, 1 bit: barrier about to close.
REQ-015 The block SHALL have port elapsed, output, 12 bits: transit time units.
REQ-016 The block SHALL have port fee_out, output, 12 bits: last charged fee.
REQ-017 The block SHALL have port balance_out, output, 12 bits: card balance after charge.
REQ-018 The block SHALL have port txn_done, output, 1 bit: one-cycle pulse, charge committed.

Function
REQ-019 Timer: init SHALL clear prescaler and elapsed next edge; init has priority over count.
REQ-020 Timer: with count=1, the prescaler SHALL increment; at TICK_DIV-1 it wraps to 0 and elapsed increments, saturating at 4095 (no wrap).
REQ-021 Timer: with count=0 and init=0, the prescaler and elapsed SHALL hold.
REQ-022 Fee: fee SHALL equal FEE_BASE + FEE_RATE*elapsed, computed combinationally from the registered elapsed at >=24-bit width and saturated to 4095.
REQ-023 Card: epass_strobe with cal=0 SHALL load balance_q=epass_balance and set card_loaded; a strobe during cal SHALL be ignored.
REQ-024 Card: valid_Epass SHALL equal card_loaded AND (balance_q >= fee), combinational from registers only, so it is valid in the same cycle cal is asserted.
REQ-025 Charge: cal=1 with valid_Epass=1 SHALL, at that edge, set balance_q = balance_q - fee, fee_out = fee, clear card_loaded, and pulse txn_done high for exactly the following cycle.
REQ-026 Charge: cal=1 with valid_Epass=0 SHALL change no card state and produce no txn_done.
REQ-027 Charge: init SHALL NOT clear card_loaded.
REQ-028 Charge: balance_out SHALL mirror balance_q.
REQ-029 Occupancy: up alone SHALL increment num_veh, saturating at 3; down alone SHALL decrement, saturating at 0; up and down together SHALL leave num_veh unchanged.
REQ-030 Barrier FSM: the states SHALL be CLOSED, OPEN and CLOSING.
REQ-031 Barrier FSM: dis SHALL force CLOSED next edge from any state, with priority over en.
REQ-032 Barrier FSM: en (dis=0) SHALL move any state to OPEN and load hold_cnt=HOLD_CYCLES-1.
REQ-033 Barrier FSM: OPEN SHALL decrement hold_cnt and at 0 go to CLOSING with warn_cnt=WARN_CYCLES-1.
REQ-034 Barrier FSM: CLOSING SHALL decrement warn_cnt and at 0 go to CLOSED.
REQ-035 Barrier FSM: enable SHALL be 1 in OPEN and CLOSING; barrier_warn SHALL be 1 only in CLOSING.

Reset
REQ-036 Reset SHALL asynchronously force num_veh=0, enable=0, barrier_warn=0, elapsed=0, prescaler=0, fee_out=0, balance_q=0, card_loaded=0 (hence valid_Epass=0), txn_done=0 and barrier state CLOSED, including mid-transaction.
REQ-037 After reset release, the first command SHALL be honoured on the first rising edge.

Verification
REQ-038 Scenario: strobe balance 100, init 1 cycle, count 40 cycles -> elapsed=10, fee 30, valid_Epass=1; cal 1 cycle -> balance_out=70, fee_out=30, txn_done high exactly 1 cycle, valid_Epass=0.
REQ-039 Scenario: balance 20, count 40 cycles (fee 30), cal -> valid_Epass=0, balance_out=20, no txn_done.
REQ-040 Scenario: up x4 -> num_veh 1,2,3,3; up and down together -> 3; down x4 -> 2,1,0,0.
REQ-041 Scenario: en -> enable=1 for 8 cycles, then barrier_warn=1 for 2 cycles, then CLOSED; en at cycle 5 restarts the 8-cycle hold; en and dis together -> CLOSED.
REQ-042 Scenario: count held 20000 cycles -> elapsed saturates at 4095, fee saturates at 4095; init and count together -> elapsed=0.
REQ-043 Scenario: reset asserted mid-OPEN with num_veh=2 and a card loaded -> all outputs at reset values immediately, without waiting for a clock edge.
